// File: rtl/memif_req_arbiter_pkg.sv
// Shared types for the memory request path: the command record carried through
// the per-port FIFOs, the credit counter type and the default sizing constants.
package memif_req_arbiter_pkg;

    localparam int MEMIF_TIDW    = 6;
    localparam int MEMIF_ADDRW   = 27;
    localparam int MAXMEMCREDIT  = 8;
    localparam int MEMIF_CREDITW = $clog2(MAXMEMCREDIT + 1);

    typedef struct packed {
        logic                   we;
        logic [MEMIF_TIDW-1:0]  tid;
        logic [MEMIF_ADDRW-1:0] addr;
        logic                   parity;
    } memif_req_type;

    typedef logic [MEMIF_CREDITW-1:0] memif_credit_type;

    // Even parity across the whole record, parity bit included: 1 means corrupted.
    function automatic logic memif_parity_err(input memif_req_type req);
        return ^req;
    endfunction

endpackage

// File: rtl/memif_req_arbiter_fifo.sv
// Per-port command FIFO: one write port, one read port, head visible combinationally.
// full/empty come straight from the registered occupancy count.
module memif_req_arbiter_fifo
    import memif_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          pop,
    input  memif_req_type wdata,
    output memif_req_type rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    memif_req_type   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            do_push;
    logic            do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage has no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/memif_req_arbiter.sv
// N-port round-robin request arbiter feeding one memory-controller command port,
// throttled by controller credits, with per-port parity checking on dequeue.
module memif_req_arbiter
    import memif_req_arbiter_pkg::*;
#(
    parameter int NPORT     = 4,
    parameter int FIFODEPTH = 8,
    parameter int TIDW      = MEMIF_TIDW,
    parameter int ADDRW     = MEMIF_ADDRW,
    parameter int MAXCREDIT = MAXMEMCREDIT,
    parameter int RIDW      = $clog2(NPORT)
) (
    input  logic                              gclk,
    input  logic                              rstn,
    input  logic [NPORT-1:0]                  req_valid,
    output logic [NPORT-1:0]                  req_ready,
    input  logic [NPORT-1:0]                  req_we,
    input  logic [NPORT*TIDW-1:0]             req_tid,
    input  logic [NPORT*ADDRW-1:0]            req_addr,
    input  logic [NPORT-1:0]                  req_parity,
    output logic                              mc_valid,
    output logic [RIDW-1:0]                   mc_rid,
    output logic                              mc_we,
    output logic [TIDW-1:0]                   mc_tid,
    output logic [ADDRW-1:0]                  mc_addr,
    output logic                              mc_parity,
    input  logic                              mc_credit_ret,
    output logic [$clog2(MAXCREDIT+1)-1:0]    credit_cnt,
    output logic [NPORT-1:0]                  perr,
    output logic                              credit_ovf
);

    localparam int CW = $clog2(MAXCREDIT + 1);

    memif_req_type    push_data [NPORT];
    memif_req_type    head      [NPORT];
    memif_req_type    gcmd;
    logic [NPORT-1:0] fifo_full;
    logic [NPORT-1:0] fifo_empty;
    logic [NPORT-1:0] pop;
    logic [NPORT-1:0] eligible;
    logic             grant_valid;
    logic [RIDW-1:0]  grant_idx;
    logic [RIDW-1:0]  idx;
    logic [RIDW-1:0]  rr_ptr;
    logic             rst_done;

    // rst_done keeps req_ready low during reset and for the first cycle after it.
    for (genvar p = 0; p < NPORT; p++) begin : g_port
        assign push_data[p] = {req_we[p], req_tid[p*TIDW +: TIDW],
                               req_addr[p*ADDRW +: ADDRW], req_parity[p]};
        assign req_ready[p] = rst_done & ~fifo_full[p];

        memif_req_arbiter_fifo #(.DEPTH(FIFODEPTH)) u_fifo (
            .clk   (gclk),
            .rstn  (rstn),
            .push  (req_valid[p] & req_ready[p]),
            .pop   (pop[p]),
            .wdata (push_data[p]),
            .rdata (head[p]),
            .full  (fifo_full[p]),
            .empty (fifo_empty[p])
        );
    end

    // Scan from the highest offset down so the nearest port at/after rr_ptr wins.
    always_comb begin
        eligible    = (credit_cnt != '0) ? ~fifo_empty : '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            idx = rr_ptr + RIDW'(i);
            if (eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
        pop = '0;
        if (grant_valid) begin
            pop[grant_idx] = 1'b1;
        end
    end

    assign gcmd = head[grant_idx];

    always_ff @(posedge gclk) begin
        if (!rstn) begin
            rst_done   <= 1'b0;
            rr_ptr     <= '0;
            mc_valid   <= 1'b0;
            mc_rid     <= '0;
            mc_we      <= 1'b0;
            mc_tid     <= '0;
            mc_addr    <= '0;
            mc_parity  <= 1'b0;
            credit_cnt <= CW'(MAXCREDIT);
            perr       <= '0;
            credit_ovf <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            mc_valid <= grant_valid;
            if (grant_valid) begin
                rr_ptr    <= grant_idx + RIDW'(1);
                mc_rid    <= grant_idx;
                mc_we     <= gcmd.we;
                mc_tid    <= gcmd.tid;
                mc_addr   <= gcmd.addr;
                mc_parity <= gcmd.parity;
                if (memif_parity_err(gcmd)) begin
                    perr[grant_idx] <= 1'b1;
                end
            end
            // A grant and a return on the same edge cancel out.
            case ({grant_valid, mc_credit_ret})
                2'b10: credit_cnt <= credit_cnt - CW'(1);
                2'b01: begin
                    if (credit_cnt == CW'(MAXCREDIT)) begin
                        credit_ovf <= 1'b1;
                    end else begin
                        credit_cnt <= credit_cnt + CW'(1);
                    end
                end
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_memif_req_arbiter.sv
// Directed bench for memif_req_arbiter: issued commands go into an expected queue,
// a negedge monitor pops and compares every mc_valid beat.
module tb_memif_req_arbiter;

    localparam int EW = 37;

    logic         gclk;
    logic         rstn;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [3:0]   req_we;
    logic [23:0]  req_tid;
    logic [107:0] req_addr;
    logic [3:0]   req_parity;
    logic         mc_valid;
    logic [1:0]   mc_rid;
    logic         mc_we;
    logic [5:0]   mc_tid;
    logic [26:0]  mc_addr;
    logic         mc_parity;
    logic         mc_credit_ret;
    logic [3:0]   credit_cnt;
    logic [3:0]   perr;
    logic         credit_ovf;

    logic [EW-1:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;
    int n_issued     = 0;
    int base;

    memif_req_arbiter dut (
        .gclk          (gclk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_tid       (req_tid),
        .req_addr      (req_addr),
        .req_parity    (req_parity),
        .mc_valid      (mc_valid),
        .mc_rid        (mc_rid),
        .mc_we         (mc_we),
        .mc_tid        (mc_tid),
        .mc_addr       (mc_addr),
        .mc_parity     (mc_parity),
        .mc_credit_ret (mc_credit_ret),
        .credit_cnt    (credit_cnt),
        .perr          (perr),
        .credit_ovf    (credit_ovf)
    );

    // Clock / reset
    initial begin
        gclk = 1'b0;
        forever #5 gclk = ~gclk;
    end

    // Scoreboard monitor
    always @(negedge gclk) begin
        logic [EW-1:0] act;
        logic [EW-1:0] exp_v;
        if (mc_valid === 1'b1) begin
            act = {mc_rid, mc_we, mc_tid, mc_addr, mc_parity};
            n_issued++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL mc_cmd: got %h, expected no command", act);
            end else begin
                exp_v = exp_q.pop_front();
                if (act !== exp_v) begin
                    tests_failed++;
                    $display("FAIL mc_cmd: got %h, expected %h", act, exp_v);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    // Drivers: inputs change right after a negedge, pulses last one posedge.
    task automatic step();
        @(negedge gclk);
        req_valid     = '0;
        mc_credit_ret = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic set_port(input int p, input logic we, input logic [5:0] tid,
                            input logic [26:0] addr, input logic flip, input bit accept);
        logic       par;
        logic [1:0] rid;
        par = (^{we, tid, addr}) ^ flip;
        rid = p[1:0];
        req_valid[p]          = 1'b1;
        req_we[p]             = we;
        req_tid[p*6 +: 6]     = tid;
        req_addr[p*27 +: 27]  = addr;
        req_parity[p]         = par;
        if (accept) exp_q.push_back({rid, we, tid, addr, par});
    endtask

    task automatic return_credits(input int n);
        for (int i = 0; i < n; i++) begin
            mc_credit_ret = 1'b1;
            step();
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        wait_cycles(2);
        check("ready_in_reset", req_ready, 4'h0);
        rstn = 1'b1;
        step();
        check("ready_after_reset", req_ready, 4'hf);
        check("mc_valid_reset", mc_valid, 1'b0);
        check("mc_fields_reset", {mc_rid, mc_we, mc_tid, mc_addr, mc_parity}, '0);
        check("credit_reset", credit_cnt, 4'd8);
        check("perr_reset", perr, 4'h0);
        check("ovf_reset", credit_ovf, 1'b0);
    endtask

    initial begin
        rstn          = 1'b0;
        req_valid     = '0;
        req_we        = '0;
        req_tid       = '0;
        req_addr      = '0;
        req_parity    = '0;
        mc_credit_ret = 1'b0;
        do_reset();

        // 1: single command latency
        set_port(0, 1'b0, 6'd5, 27'h1234, 1'b0, 1'b1);
        step();
        check("t1_valid_early", mc_valid, 1'b0);
        step();
        check("t1_valid", mc_valid, 1'b1);
        check("t1_credit", credit_cnt, 4'd7);
        wait_cycles(2);

        // 2: four simultaneous pushes, round robin from port 0
        do_reset();
        for (int p = 0; p < 4; p++) set_port(p, p[0], 6'(p + 10), 27'(32'h2000 + p), 1'b0, 1'b1);
        step();
        check("t2_valid_early", mc_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_valid_burst", mc_valid, 1'b1);
        end
        step();
        check("t2_valid_end", mc_valid, 1'b0);
        check("t2_credit", credit_cnt, 4'd4);
        return_credits(4);
        check("t2_credit_back", credit_cnt, 4'd8);

        // 3: credit exhaustion on port 1, then one returned credit
        base = n_issued;
        for (int i = 0; i < 9; i++) begin
            set_port(1, i[0], 6'(i + 1), 27'(32'h100 + i), 1'b0, 1'b1);
            step();
        end
        wait_cycles(3);
        check("t3_issued8", n_issued - base, 8);
        check("t3_credit0", credit_cnt, 4'd0);
        return_credits(1);
        wait_cycles(3);
        check("t3_issued9", n_issued - base, 9);
        check("t3_credit_end", credit_cnt, 4'd0);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: fill port 2 with no credit, drop the 9th, drain in order
        base = n_issued;
        for (int i = 0; i < 8; i++) begin
            set_port(2, ~i[0], 6'(i + 32), 27'(32'h3000 + 2 * i), 1'b0, 1'b1);
            step();
        end
        check("t4_ready_full", req_ready[2], 1'b0);
        check("t4_ready_others", {req_ready[3], req_ready[1:0]}, 3'b111);
        set_port(2, 1'b1, 6'd63, 27'h7ff_ffff, 1'b0, 1'b0);
        step();
        check("t4_none_issued", n_issued - base, 0);
        return_credits(8);
        wait_cycles(4);
        check("t4_issued8", n_issued - base, 8);
        check("t4_credit0", credit_cnt, 4'd0);
        return_credits(8);
        check("t4_credit8", credit_cnt, 4'd8);

        // 5: bad parity on port 3 is flagged but still forwarded
        set_port(3, 1'b1, 6'h2a, 27'h5abcde1, 1'b1, 1'b1);
        wait_cycles(3);
        check("t5_perr", perr, 4'b1000);
        check("t5_credit", credit_cnt, 4'd7);
        return_credits(1);
        wait_cycles(5);
        check("t5_perr_sticky", perr, 4'b1000);

        // 6: overflow, then reset with queued commands
        return_credits(2);
        check("t6_ovf", credit_ovf, 1'b1);
        check("t6_credit_held", credit_cnt, 4'd8);
        for (int i = 0; i < 8; i++) begin
            set_port(0, i[1], 6'(i + 48), 27'(32'h40000 + i), 1'b0, 1'b1);
            step();
        end
        wait_cycles(3);
        check("t6_credit0", credit_cnt, 4'd0);
        for (int i = 0; i < 3; i++) begin
            set_port(1, 1'b1, 6'(i), 27'(32'h50000 + i), 1'b0, 1'b0);
            step();
        end
        check("t6_queue_drained", exp_q.size(), 0);
        check("t6_perr_before_reset", perr, 4'b1000);
        do_reset();
        wait_cycles(10);

        // Round-robin pointer restarts at port 0
        set_port(0, 1'b0, 6'd7, 27'h0abc, 1'b0, 1'b1);
        set_port(1, 1'b1, 6'd9, 27'h0def, 1'b0, 1'b1);
        step();
        wait_cycles(5);
        check("t6_credit_after", credit_cnt, 4'd6);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/memif_req_arbiter.md
Name: memif_req_arbiter

Overview:
Parametrised N-port memory request arbiter between the per-pipeline I/D request sources and one memory-controller command port. Each port has its own command FIFO. A round-robin arbiter forwards at most one command per cycle, gated by a credit counter that tracks free slots in the controller. Each command is parity-checked as it leaves its FIFO, and the originating port ID (rid) travels with it so returned data can be routed back.

Parameters:
NPORT, 4, number of requestor ports (power of 2, ≥2)
FIFODEPTH, 8, entries per port FIFO (power of 2, ≥2)
TIDW, 6, thread-ID width (NTHREADIDMSB+1)
ADDRW, 27, burst-aligned address width (bits 31:5)
MAXCREDIT, 8, controller command-buffer slots
RIDW, log2x(NPORT), requestor-ID width

Ports:
gclk  in  1  clock
rstn  in  1  reset
req_valid  in  NPORT  per-port request valid
req_ready  out  NPORT  per-port FIFO not full
req_we  in  NPORT  per-port write flag
req_tid  in  NPORT*TIDW  per-port thread ID, port p at [p*TIDW +: TIDW]
req_addr  in  NPORT*ADDRW  per-port address, packed like req_tid
req_parity  in  NPORT  even parity over {we,tid,addr}
mc_valid  out  1  command valid to controller
mc_rid  out  RIDW  originating port
mc_we  out  1  write flag
mc_tid  out  TIDW  thread ID
mc_addr  out  ADDRW  address
mc_parity  out  1  stored parity, forwarded unchanged
mc_credit_ret  in  1  controller freed one slot this cycle
credit_cnt  out  log2x(MAXCREDIT+1)  current credits
perr  out  NPORT  sticky parity error per port
credit_ovf  out  1  sticky: credit returned while count == MAXCREDIT

Behaviour:
- Reset is synchronous and active-low (rstn=0 sampled on gclk rising edge). No other clock.
- Reset values:
  - all FIFOs empty, so req_ready = all 1s one cycle after reset release; req_ready is 0 while rstn=0
  - mc_valid=0, mc_rid/we/tid/addr/parity=0
  - credit_cnt=MAXCREDIT; perr=0; credit_ovf=0; RR pointer=0
- Reset mid-operation flushes all queued commands; no partial command is issued.
- Push: port p enqueues on an edge where req_valid[p] && req_ready[p]. req_ready[p] = (count[p] != FIFODEPTH), derived from registered count.
  - Pushing while not ready: command dropped, no error flagged.
  - Push and pop on the same port and edge: count unchanged.
- Arbitration, evaluated each cycle:
  - eligible = ports with count != 0, considered only if credit_cnt != 0
  - grant the first eligible port at or after the RR pointer, wrapping modulo NPORT
  - on a grant to port g: pop g, set RR pointer = (g+1) mod NPORT, register the command to mc_*
  - mc_valid is registered: 1 for exactly one cycle per grant, 0 otherwise. Back-to-back grants give continuous mc_valid.
- Latency: a command accepted at edge k into an empty FIFO, with credit available and no competition, is presented with mc_valid=1 in the cycle after edge k+1.
- Credits:
  - a grant decrements credit_cnt; mc_credit_ret increments it
  - both on the same edge: unchanged
  - credit_cnt=0 blocks grants; mc_credit_ret can still raise it, and the first grant follows on the next edge
  - mc_credit_ret when credit_cnt==MAXCREDIT: count held, credit_ovf set
- Parity: on pop, recompute the XOR of {we,tid,addr,parity}.
  - nonzero result sets perr[g], which stays set until reset
  - the command is still forwarded with its original parity
- Ordering: FIFO order within a port is preserved. There is no ordering guarantee across ports.
- No command is lost or duplicated under any combination of pushes, grants and credit returns.

Decomposition:
- libmemif package gains:
  - memif_req_type (packed: we, tid, addr, parity; width 2+TIDW+ADDRW)
  - memif_credit_type
  - MAXMEMCREDIT-derived defaults
  - a parity function for memif_req_type
- One sub-module, memif_req_fifo: single-port-write/single-port-read LUTRAM FIFO of memif_req_type, with registered count, full and empty outputs. It is instantiated NPORT times.
- The top level holds the RR arbiter, credit counter, output register and error flags.

Test Plan:
1. Reset, then port 0 pushes {we=0,tid=5,addr=0x1234,parity=ok} at edge 1 → mc_valid=1 in cycle after edge 2 with rid=0,tid=5,addr=0x1234; credit_cnt goes 8→7.
2. All 4 ports push one command at the same edge → grants to rid 0,1,2,3 on consecutive cycles, mc_valid high for 4 cycles, credit_cnt ends at 4.
3. MAXCREDIT=8, port 1 pushes 8 commands with no credit return → exactly 8 issued, credit_cnt=0. Pulse mc_credit_ret once → one more command issued, credit_cnt returns to 0.
4. Port 2 pushes 8 commands with credit_cnt=0 → req_ready[2]=0 after the 8th; a 9th push is dropped. After credits return, exactly 8 commands issue in push order.
5. Port 3 pushes a command with flipped parity → command still forwarded with its original parity, perr=4'b1000, and perr stays set until rstn=0.
6. Hold mc_credit_ret=1 at credit_cnt=8 → credit_ovf=1, credit_cnt stays 8. Assert rstn=0 with 3 queued commands → queues flushed, no mc_valid after reset, credit_cnt=8.
